// File: rtl/core_pkg.sv
// Shared constants, pipeline-record type and helpers for the D-stage hazard
// and forwarding controller.
package core_pkg;

    localparam int REG_AW = 5;
    localparam int T_W    = 2;

    // D-stage operand selects
    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_E     = 2'd1;
    localparam logic [1:0] FWD_M     = 2'd2;

    // E-stage operand selects
    localparam logic [1:0] FWD_EREG  = 2'd0;
    localparam logic [1:0] FWD_MRES  = 2'd1;
    localparam logic [1:0] FWD_WDATA = 2'd2;

    localparam logic [T_W-1:0] TUSE_NONE = 2'd3;

    // How a stage register transforms tnew as a record moves into it
    localparam logic [1:0] TNEW_PASS = 2'd0;
    localparam logic [1:0] TNEW_DEC  = 2'd1;
    localparam logic [1:0] TNEW_CLR  = 2'd2;

    typedef struct packed {
        logic [REG_AW-1:0] dst;
        logic [T_W-1:0]    tnew;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
    } hz_rec_t;

    function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] x);
        return (x == '0) ? '0 : x - 1'b1;
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline record register (E, M or W) with synchronous reset, bubble
// insertion and a per-stage tnew transform.
module hazard_stage_reg
    import core_pkg::*;
#(
    parameter logic [1:0] TNEW_MODE = TNEW_PASS,
    parameter bit         KEEP_SRC  = 1'b1
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    i_bubble,
    input  hz_rec_t i_rec,
    output hz_rec_t o_rec
);

    hz_rec_t w_next;
    hz_rec_t r_rec;

    // Only E needs source addresses; later stages drop them so they stay zero.
    always_comb begin
        w_next = i_rec;
        case (TNEW_MODE)
            TNEW_DEC: w_next.tnew = sat_dec(i_rec.tnew);
            TNEW_CLR: w_next.tnew = '0;
            default:  w_next.tnew = i_rec.tnew;
        endcase
        if (!KEEP_SRC) begin
            w_next.rs = '0;
            w_next.rt = '0;
        end
        if (i_bubble) begin
            w_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rec <= '0;
        end else begin
            r_rec <= w_next;
        end
    end

    assign o_rec = r_rec;

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage stall and forward-select generation from the E/M/W record pipeline;
// all outputs are combinational from the records and the D-stage inputs.
module hazard_scoreboard
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic [T_W-1:0]    tuse_rs_d,
    input  logic [T_W-1:0]    tuse_rt_d,
    input  logic [REG_AW-1:0] dst_d,
    input  logic [T_W-1:0]    tnew_d,
    input  logic              md_busy,
    output logic              stall,
    output logic [1:0]        fwd_d_rs,
    output logic [1:0]        fwd_d_rt,
    output logic [1:0]        fwd_e_rs,
    output logic [1:0]        fwd_e_rt
);

    hz_rec_t w_recD;
    hz_rec_t w_recE;
    hz_rec_t w_recM;
    hz_rec_t w_recW;
    logic    w_rsHz;
    logic    w_rtHz;

    assign w_recD = '{dst: dst_d, tnew: tnew_d, rs: rs_d, rt: rt_d};

    hazard_stage_reg #(.TNEW_MODE(TNEW_PASS), .KEEP_SRC(1'b1)) u_stageE (
        .clk(clk), .reset(reset), .i_bubble(stall), .i_rec(w_recD), .o_rec(w_recE)
    );

    hazard_stage_reg #(.TNEW_MODE(TNEW_DEC), .KEEP_SRC(1'b0)) u_stageM (
        .clk(clk), .reset(reset), .i_bubble(1'b0), .i_rec(w_recE), .o_rec(w_recM)
    );

    hazard_stage_reg #(.TNEW_MODE(TNEW_CLR), .KEEP_SRC(1'b0)) u_stageW (
        .clk(clk), .reset(reset), .i_bubble(1'b0), .i_rec(w_recM), .o_rec(w_recW)
    );

    // A producer stalls D only while its result is later than the consumer's need.
    assign w_rsHz = (rs_d != '0) &&
                    (((w_recE.dst == rs_d) && (w_recE.tnew > tuse_rs_d)) ||
                     ((w_recM.dst == rs_d) && (w_recM.tnew > tuse_rs_d)));
    assign w_rtHz = (rt_d != '0) &&
                    (((w_recE.dst == rt_d) && (w_recE.tnew > tuse_rt_d)) ||
                     ((w_recM.dst == rt_d) && (w_recM.tnew > tuse_rt_d)));
    assign stall  = w_rsHz || w_rtHz || md_busy;

    always_comb begin
        fwd_d_rs = FWD_RF;
        if (rs_d != '0) begin
            if ((w_recE.dst == rs_d) && (w_recE.tnew == '0)) begin
                fwd_d_rs = FWD_E;
            end else if ((w_recM.dst == rs_d) && (w_recM.tnew == '0)) begin
                fwd_d_rs = FWD_M;
            end
        end
    end

    always_comb begin
        fwd_d_rt = FWD_RF;
        if (rt_d != '0) begin
            if ((w_recE.dst == rt_d) && (w_recE.tnew == '0)) begin
                fwd_d_rt = FWD_E;
            end else if ((w_recM.dst == rt_d) && (w_recM.tnew == '0)) begin
                fwd_d_rt = FWD_M;
            end
        end
    end

    // W-to-D needs no select: the register file bypasses same-cycle writes.
    always_comb begin
        fwd_e_rs = FWD_EREG;
        if (w_recE.rs != '0) begin
            if ((w_recM.dst == w_recE.rs) && (w_recM.tnew == '0)) begin
                fwd_e_rs = FWD_MRES;
            end else if (w_recW.dst == w_recE.rs) begin
                fwd_e_rs = FWD_WDATA;
            end
        end
    end

    always_comb begin
        fwd_e_rt = FWD_EREG;
        if (w_recE.rt != '0) begin
            if ((w_recM.dst == w_recE.rt) && (w_recM.tnew == '0)) begin
                fwd_e_rt = FWD_MRES;
            end else if (w_recW.dst == w_recE.rt) begin
                fwd_e_rt = FWD_WDATA;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard: load-use stalls,
// forwarding priorities, register-0 masking, md_busy bubbles and reset.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic [1:0] tuse_rs_d;
    logic [1:0] tuse_rt_d;
    logic [4:0] dst_d;
    logic [1:0] tnew_d;
    logic       md_busy;
    logic       stall;
    logic [1:0] fwd_d_rs;
    logic [1:0] fwd_d_rt;
    logic [1:0] fwd_e_rs;
    logic [1:0] fwd_e_rt;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset),
        .rs_d(rs_d), .rt_d(rt_d),
        .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
        .dst_d(dst_d), .tnew_d(tnew_d), .md_busy(md_busy),
        .stall(stall),
        .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
        .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [1:0] trs, input logic [1:0] trt,
                                 input logic [4:0] dst, input logic [1:0] tnew,
                                 input logic md);
        rs_d      = rs;
        rt_d      = rt;
        tuse_rs_d = trs;
        tuse_rt_d = trt;
        dst_d     = dst;
        tnew_d    = tnew;
        md_busy   = md;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        doReset();
        checkOutput("rst_stall", {1'b0, stall}, 2'd0);
        checkOutput("rst_fwd_d_rs", fwd_d_rs, 2'd0);
        checkOutput("rst_fwd_d_rt", fwd_d_rt, 2'd0);
        checkOutput("rst_fwd_e_rs", fwd_e_rs, 2'd0);
        checkOutput("rst_fwd_e_rt", fwd_e_rt, 2'd0);

        // 1: load r8 then add using rs=8 in E (tuse 1)
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, 1'b0);
        tick();
        applyStimulus(5'd8, 5'd0, 2'd1, 2'd3, 5'd10, 2'd1, 1'b0);
        checkOutput("t1_stall_c0", {1'b0, stall}, 2'd1);
        tick();
        checkOutput("t1_stall_c1", {1'b0, stall}, 2'd0);
        checkOutput("t1_fwd_d_rs_c1", fwd_d_rs, 2'd0);
        tick();
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0);
        checkOutput("t1_fwd_e_rs_wdata", fwd_e_rs, 2'd2);

        // 2: load r8 then beq rs=8 (tuse 0): two stall cycles
        doReset();
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, 1'b0);
        tick();
        applyStimulus(5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0);
        checkOutput("t2_stall_c0", {1'b0, stall}, 2'd1);
        tick();
        checkOutput("t2_stall_c1", {1'b0, stall}, 2'd1);
        tick();
        checkOutput("t2_stall_c2", {1'b0, stall}, 2'd0);
        checkOutput("t2_fwd_d_rs_c2", fwd_d_rs, 2'd0);

        // 3: addu r9 then beq rt=9 (tuse 0): one stall, then M forward
        doReset();
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd1, 1'b0);
        tick();
        applyStimulus(5'd0, 5'd9, 2'd3, 2'd0, 5'd0, 2'd0, 1'b0);
        checkOutput("t3_stall_c0", {1'b0, stall}, 2'd1);
        tick();
        checkOutput("t3_stall_c1", {1'b0, stall}, 2'd0);
        checkOutput("t3_fwd_d_rt", fwd_d_rt, 2'd2);
        checkOutput("t3_fwd_d_rs", fwd_d_rs, 2'd0);

        // 3b: two addu r9 back to back, then or with rs=9 and rt=9 used in E
        doReset();
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd1, 1'b0);
        tick();
        checkOutput("t3b_stall_a2", {1'b0, stall}, 2'd0);
        tick();
        applyStimulus(5'd9, 5'd9, 2'd1, 2'd1, 5'd11, 2'd1, 1'b0);
        checkOutput("t3b_stall_or", {1'b0, stall}, 2'd0);
        tick();
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0);
        checkOutput("t3b_fwd_e_rs_m", fwd_e_rs, 2'd1);
        checkOutput("t3b_fwd_e_rt_m", fwd_e_rt, 2'd1);

        // 4: addu r9 in M, lui r9 in E, D reads r9 at D: E wins
        doReset();
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd1, 1'b0);
        tick();
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd0, 1'b0);
        tick();
        applyStimulus(5'd9, 5'd9, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0);
        checkOutput("t4_stall", {1'b0, stall}, 2'd0);
        checkOutput("t4_fwd_d_rs", fwd_d_rs, 2'd1);
        checkOutput("t4_fwd_d_rt", fwd_d_rt, 2'd1);

        // 5: register 0 never matches; md_busy alone stalls and bubbles E
        doReset();
        applyStimulus(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0);
        tick();
        tick();
        checkOutput("t5_r0_stall", {1'b0, stall}, 2'd0);
        checkOutput("t5_r0_fwd_d_rs", fwd_d_rs, 2'd0);
        checkOutput("t5_r0_fwd_d_rt", fwd_d_rt, 2'd0);
        checkOutput("t5_r0_fwd_e_rs", fwd_e_rs, 2'd0);
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd2, 1'b1);
        checkOutput("t5_md_stall", {1'b0, stall}, 2'd1);
        tick();
        applyStimulus(5'd5, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0);
        checkOutput("t5_bubble_stall", {1'b0, stall}, 2'd0);
        checkOutput("t5_bubble_fwd", fwd_d_rs, 2'd0);

        // 6: reset while a load-use stall is pending
        doReset();
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, 1'b0);
        tick();
        applyStimulus(5'd8, 5'd8, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0);
        checkOutput("t6_stall_pre", {1'b0, stall}, 2'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checkOutput("t6_stall_post", {1'b0, stall}, 2'd0);
        checkOutput("t6_fwd_e_rs", fwd_e_rs, 2'd0);
        checkOutput("t6_fwd_e_rt", fwd_e_rt, 2'd0);
        checkOutput("t6_fwd_d_rs", fwd_d_rs, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
